// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: FSM states, buffered {instr, pc} entry, PC constants.
// Pure declarations, no timing or flow control of its own.
package fetch_pkg;

  localparam int DATA_W         = 32;
  localparam int INSTR_BYTES    = 4;
  localparam int PC_READ_OFFSET = 8;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_REDIRECT
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, branch redirect, decoder handshake.
// master = fetch unit side, slave = memory/execute/decoder side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_pc;
  logic [XLEN-1:0] imem_instr;
  logic            branch_valid;
  logic [XLEN-1:0] branch_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus8;

  modport master (
    output imem_pc, dec_valid, dec_instr, dec_pc, dec_pc_plus8,
    input  imem_instr, branch_valid, branch_target, dec_ready
  );

  modport slave (
    input  imem_pc, dec_valid, dec_instr, dec_pc, dec_pc_plus8,
    output imem_instr, branch_valid, branch_target, dec_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// Skid FIFO of fetched {instr, pc}: registered head, no push-to-pop bypass, 1-cycle latency.
// Flush empties it in one cycle; the producer must never push when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: word-aligned PC, 1-cycle imem latency tracking, skid FIFO; issue->dec_valid = 2 cycles.
// Fetch is credit-limited so FIFO + in-flight never exceeds FIFO_DEPTH; outputs hold while dec_ready=0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = DATA_W,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  fetch_state_t               state_q, state_d;
  logic [XLEN-1:0]            pc_q, pc_d;
  logic [XLEN-1:0]            resp_pc_q, resp_pc_d;
  logic                       resp_valid_q, resp_valid_d;

  logic                       pop;
  logic                       push;
  logic                       issue;
  logic [CW-1:0]              occupancy;
  fetch_entry_t               push_dat;
  fetch_entry_t               head_dat;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_full;
  logic                       fifo_empty;

  assign pop  = ~fifo_empty & bus.dec_ready;
  // A response arriving while a branch is taken belongs to the old stream.
  assign push = resp_valid_q & ~bus.branch_valid;

  assign push_dat.instr = bus.imem_instr;
  assign push_dat.pc    = resp_pc_q;

  // Slots already spoken for after this cycle: buffered + in flight - leaving.
  assign occupancy = CW'(fifo_count) + CW'(resp_valid_q) - CW'(pop);
  assign issue     = (state_q != S_BOOT) && !bus.branch_valid &&
                     (occupancy < CW'(FIFO_DEPTH));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = 1'b0;
    unique case (state_q)
      S_BOOT:     state_d = S_RUN;
      S_RUN:      state_d = bus.branch_valid ? S_REDIRECT : S_RUN;
      S_REDIRECT: state_d = S_RUN;
      default:    state_d = S_BOOT;
    endcase
    if (bus.branch_valid) begin
      pc_d = align_word(bus.branch_target);
    end else if (issue) begin
      pc_d         = pc_q + XLEN'(INSTR_BYTES);
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      resp_pc_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (bus.branch_valid),
    .head_dat (head_dat),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.imem_pc      = pc_q;
  assign bus.dec_valid    = ~fifo_empty;
  assign bus.dec_instr    = head_dat.instr;
  assign bus.dec_pc       = head_dat.pc;
  assign bus.dec_pc_plus8 = head_dat.pc + XLEN'(PC_READ_OFFSET);

  a_no_overflow : assert property (@(posedge clk) disable iff (!reset) push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table, random backpressure/branch phase,
// and an in-order scoreboard of expected {pc, instr} transfers to the decoder.
module tb_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        chk;
    logic        rst_chk;
    logic        exp_vld;
    logic [31:0] exp_imem;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_xfers;
  exp_t sb_q[$];
  logic [31:0] exp_next;
  vec_t vecs[32];

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'hE3A0_0001;
      32'h4:   return 32'hE3A0_1002;
      32'h8:   return 32'hE080_0001;
      default: return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endcase
  endfunction

  // Instruction memory: one-cycle registered read.
  always @(posedge clk) bus.imem_instr <= mem_word(bus.imem_pc);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: each decoder transfer is compared against the next expected word.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_next = 32'h0;
    end else begin
      if (bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
        n_xfers++;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_pc", bus.dec_pc, e.pc);
          check("sb_instr", bus.dec_instr, e.instr);
        end
      end
      if (bus.branch_valid === 1'b1) begin
        sb_q.delete();
        exp_next = {bus.branch_target[31:2], 2'b00};
      end
    end
    while (sb_q.size() < 4) begin
      sb_q.push_back('{pc: exp_next, instr: mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  end

  function automatic vec_t v(input logic r, input logic rdy, input logic br, input logic [31:0] tgt,
                             input logic chk, input logic rc, input logic ev,
                             input logic [31:0] eimem, input logic [31:0] epc);
    vec_t x;
    x.rst_n = r; x.rdy = rdy; x.br = br; x.tgt = tgt; x.chk = chk; x.rst_chk = rc;
    x.exp_vld = ev; x.exp_imem = eimem; x.exp_pc = epc;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
    rst_n = r;
    bus.dec_ready = rdy;
    bus.branch_valid = br;
    bus.branch_target = tgt;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [31:0] eimem,
                           input logic [31:0] epc);
    check({tag, "_vld"}, {31'd0, bus.dec_valid}, {31'd0, ev});
    check({tag, "_imem_pc"}, bus.imem_pc, eimem);
    if (ev) begin
      check({tag, "_pc"}, bus.dec_pc, epc);
      check({tag, "_instr"}, bus.dec_instr, mem_word(epc));
      check({tag, "_pc8"}, bus.dec_pc_plus8, epc + 32'd8);
    end
  endtask

  initial begin
    int xf0;
    n_checks = 0;
    n_fail = 0;
    n_xfers = 0;
    exp_next = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    //          rst rdy br  tgt            chk rc  vld imem_pc        dec_pc
    vecs[0]  = v(0, 0, 0, 32'h0,          0,  0,  0, 32'h0,          32'h0);
    vecs[1]  = v(1, 1, 0, 32'h0,          1,  1,  0, 32'h0,          32'h0);
    vecs[2]  = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0);
    vecs[3]  = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h4,          32'h0);
    vecs[4]  = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h8,          32'h0);
    vecs[5]  = v(1, 1, 0, 32'h0,          1,  0,  1, 32'hC,          32'h4);
    vecs[6]  = v(1, 0, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[7]  = v(1, 0, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[8]  = v(1, 0, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[9]  = v(1, 0, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[10] = v(1, 0, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[11] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h10,         32'h8);
    vecs[12] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h14,         32'hC);
    vecs[13] = v(1, 1, 1, 32'h40,         1,  0,  1, 32'h18,         32'h10);
    vecs[14] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h40,         32'h0);
    vecs[15] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h44,         32'h0);
    vecs[16] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h48,         32'h40);
    vecs[17] = v(1, 1, 1, 32'h43,         1,  0,  1, 32'h4C,         32'h44);
    vecs[18] = v(1, 1, 1, 32'h80,         1,  0,  0, 32'h40,         32'h0);
    vecs[19] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h80,         32'h0);
    vecs[20] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h84,         32'h0);
    vecs[21] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h88,         32'h80);
    vecs[22] = v(0, 1, 1, 32'h100,        1,  0,  1, 32'h8C,         32'h84);
    vecs[23] = v(1, 1, 0, 32'h0,          1,  1,  0, 32'h0,          32'h0);
    vecs[24] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0);
    vecs[25] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h4,          32'h0);
    vecs[26] = v(1, 1, 1, 32'hFFFF_FFFC,  1,  0,  1, 32'h8,          32'h0);
    vecs[27] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'hFFFF_FFFC,  32'h0);
    vecs[28] = v(1, 1, 0, 32'h0,          1,  0,  0, 32'h0,          32'h0);
    vecs[29] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h4,          32'hFFFF_FFFC);
    vecs[30] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'h8,          32'h0);
    vecs[31] = v(1, 1, 0, 32'h0,          1,  0,  1, 32'hC,          32'h4);

    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick();
      if (vecs[i].chk) begin
        check_out($sformatf("row%0d", i), vecs[i].exp_vld, vecs[i].exp_imem, vecs[i].exp_pc);
        if (vecs[i].rst_chk) begin
          check($sformatf("row%0d_rst_instr", i), bus.dec_instr, 32'h0);
          check($sformatf("row%0d_rst_pc", i), bus.dec_pc, 32'h0);
          check($sformatf("row%0d_rst_pc8", i), bus.dec_pc_plus8, 32'h8);
        end
      end
      drive(vecs[i].rst_n, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
    end

    // Random backpressure and occasional (possibly unaligned) redirects.
    xf0 = n_xfers;
    for (int c = 0; c < 300; c++) begin
      tick();
      if ($urandom_range(0, 15) == 0)
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, $urandom & 32'h0000_0FFF);
      else
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    end
    check("rand_progress", {31'd0, (n_xfers - xf0) >= 40}, 32'd1);

    // Fill the FIFO under backpressure, then redirect while it is full.
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b1, 1'b1, 1'b0, 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("full_vld", {31'd0, bus.dec_valid}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h200);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    check_out("fbr1", 1'b0, 32'h200, 32'h0);
    tick();
    check_out("fbr2", 1'b0, 32'h204, 32'h0);
    tick();
    check_out("fbr3", 1'b1, 32'h208, 32'h200);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int c = 0; c < 8; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
